// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART RX scheduler: config FSM encoding, live-setting
// defaults and the set of oversampling ratios the RX core supports.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } cfg_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic [5:0] DEF_PRESCALE = PRESCALE_16;
  localparam logic       DEF_PAR_EN   = 1'b1;
  localparam logic       DEF_PAR_TYP  = 1'b0;

  localparam int ERR_W_DEF = 8;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sched_if.sv
// Host/RX-core facing signal bundle of the RX scheduler; slave is the scheduler side.
interface uart_rx_sched_if #(parameter int ERR_W = 8);
  logic             RX_IN;
  logic             rx_in_gated;
  logic             cfg_wr;
  logic [5:0]       cfg_prescale;
  logic             cfg_par_en;
  logic             cfg_par_typ;
  logic             cfg_err;
  logic             cfg_busy;
  logic [5:0]       Prescale;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             rx_busy;
  logic [7:0]       rx_data;
  logic             rx_data_valid;
  logic             rx_par_err;
  logic             rx_stp_err;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic [ERR_W-1:0] par_err_cnt;
  logic [ERR_W-1:0] stp_err_cnt;
  logic             clr_stat;

  modport slave (
    input  RX_IN, cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, rx_busy,
           rx_data, rx_data_valid, rx_par_err, rx_stp_err, out_ready, clr_stat,
    output rx_in_gated, cfg_err, cfg_busy, Prescale, PAR_EN, PAR_TYP,
           out_data, out_valid, overflow, par_err_cnt, stp_err_cnt
  );

  modport master (
    output RX_IN, cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, rx_busy,
           rx_data, rx_data_valid, rx_par_err, rx_stp_err, out_ready, clr_stat,
    input  rx_in_gated, cfg_err, cfg_busy, Prescale, PAR_EN, PAR_TYP,
           out_data, out_valid, overflow, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes when full are accepted only alongside a pop, pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head is zero while empty so the stale array contents never leak out.
  assign rdata = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_ONE;
      if (rd_en) rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/uart_rx_sched.sv
// UART RX scheduler: applies host config only between frames, buffers received
// bytes for the host and keeps parity/stop error statistics.
module uart_rx_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 4,
  parameter int ERR_W      = uart_rx_pkg::ERR_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_sched_if.slave bus
);
  import uart_rx_pkg::*;

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]    SW_ONE      = 1;
  localparam logic [ERR_W-1:0] ERR_ONE     = 1;

  cfg_state_e       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             cfg_err_q;
  logic             load_live;
  logic             wr_ok, wr_bad;
  logic [5:0]       presc_q, sh_presc_q;
  logic             par_en_q, par_typ_q, sh_par_en_q, sh_par_typ_q;
  logic             fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic             pop, ovf_evt;
  logic             ovf_q;
  logic [ERR_W-1:0] par_cnt_q, stp_cnt_q;

  assign wr_ok  = bus.cfg_wr &&  prescale_legal(bus.cfg_prescale);
  assign wr_bad = bus.cfg_wr && !prescale_legal(bus.cfg_prescale);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    load_live = 1'b0;
    unique case (state_q)
      ST_RUN:   if (wr_ok) state_d = ST_PEND;
      ST_PEND:  if (!bus.rx_busy && bus.RX_IN) state_d = ST_APPLY;
      ST_APPLY: begin
        load_live = 1'b1;
        cnt_d     = SETTLE_LOAD;
        state_d   = ST_SETTLE;
        if (wr_ok) pend_d = 1'b1;
      end
      ST_SETTLE: begin
        // A write arriving during the settle window is held until the window closes.
        if (cnt_q == '0) begin
          state_d = (pend_q || wr_ok) ? ST_PEND : ST_RUN;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - SW_ONE;
          if (wr_ok) pend_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      presc_q   <= DEF_PRESCALE;
      par_en_q  <= DEF_PAR_EN;
      par_typ_q <= DEF_PAR_TYP;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cfg_err_q <= wr_bad;
      if (load_live) begin
        presc_q   <= sh_presc_q;
        par_en_q  <= sh_par_en_q;
        par_typ_q <= sh_par_typ_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      sh_presc_q   <= bus.cfg_prescale;
      sh_par_en_q  <= bus.cfg_par_en;
      sh_par_typ_q <= bus.cfg_par_typ;
    end
  end

  assign bus.rx_in_gated = bus.RX_IN || (state_q == ST_APPLY) || (state_q == ST_SETTLE);
  assign bus.cfg_busy    = (state_q != ST_RUN);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.Prescale    = presc_q;
  assign bus.PAR_EN      = par_en_q;
  assign bus.PAR_TYP     = par_typ_q;

  assign pop     = bus.out_ready && !fifo_empty;
  assign ovf_evt = bus.rx_data_valid && fifo_full && !pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.rx_data_valid),
    .pop   (pop),
    .wdata (bus.rx_data),
    .rdata (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q     <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else if (bus.clr_stat) begin
      ovf_q     <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      if (ovf_evt) ovf_q <= 1'b1;
      if (bus.rx_par_err && !(&par_cnt_q)) par_cnt_q <= par_cnt_q + ERR_ONE;
      if (bus.rx_stp_err && !(&stp_cnt_q)) stp_cnt_q <= stp_cnt_q + ERR_ONE;
    end
  end

  assign bus.overflow    = ovf_q;
  assign bus.par_err_cnt = par_cnt_q;
  assign bus.stp_err_cnt = stp_cnt_q;
endmodule

// File: tb/tb_uart_rx_sched.sv
// Randomised scoreboard bench for uart_rx_sched: byte queue and live-setting queue
// are filled by the stimulus side and drained by an independent monitor.
module tb_uart_rx_sched;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 4;
  localparam logic [7:0] DEF_LIVE = {6'd16, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_sched_if #(.ERR_W(8)) bus();

  uart_rx_sched #(.FIFO_DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .ERR_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         err_seen = 0;
  bit         mon_en   = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] cfg_q[$];
  int         occ_now  = 0;
  int         occ_next = 0;
  logic       m_ovf    = 1'b0;
  logic [7:0] m_live   = DEF_LIVE;
  logic [7:0] prev_live = DEF_LIVE;
  logic [7:0] mon_cur, mon_exp;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic bit legal(input logic [5:0] p);
    return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

  // One clock of FIFO stimulus plus the reference queue update for that cycle.
  task automatic fifo_cycle(input logic push, input logic [7:0] d, input logic rdy);
    bit pop_m, acc;
    @(negedge clk);
    occ_now = occ_next;
    pop_m = rdy && (occ_now > 0);
    acc   = push && ((occ_now < DEPTH) || pop_m);
    if (push && !acc) m_ovf = 1'b1;
    if (acc) exp_q.push_back(d);
    occ_next = occ_now + (acc ? 1 : 0) - (pop_m ? 1 : 0);
    bus.rx_data_valid = push;
    bus.rx_data       = d;
    bus.out_ready     = rdy;
  endtask

  task automatic idle();
    fifo_cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic cfg_write(input logic [5:0] ps, input logic en, input logic typ);
    idle();
    bus.cfg_wr = 1'b1; bus.cfg_prescale = ps; bus.cfg_par_en = en; bus.cfg_par_typ = typ;
    idle();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic expect_live(input logic [7:0] v);
    if (v !== m_live) begin
      cfg_q.push_back(v);
      m_live = v;
    end
  endtask

  task automatic clr_stats();
    idle(); bus.clr_stat = 1'b1;
    idle(); bus.clr_stat = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic wait_cfg_idle(input string name);
    int k;
    k = 0;
    #2;
    while (bus.cfg_busy === 1'b1 && k < 40) begin
      idle(); #2; k++;
    end
    check(name, 32'(bus.cfg_busy), 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    occ_now = 0; occ_next = 0; m_ovf = 1'b0;
    exp_q.delete();
    expect_live(DEF_LIVE);
    bus.cfg_wr = 1'b0; bus.clr_stat = 1'b0;
    idle(); idle();
    rst = 1'b0;
  endtask

  task automatic cfg_round();
    int n, nbad, e0;
    logic [7:0] expv;
    logic [5:0] ps;
    logic en, typ;
    bit any;
    expv = m_live; nbad = 0; any = 1'b0;
    idle(); bus.rx_busy = 1'b1;
    e0 = err_seen;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: ps = 6'd8;
        1: ps = 6'd16;
        2: ps = 6'd32;
        default: ps = 6'($urandom);
      endcase
      en = 1'($urandom); typ = 1'($urandom);
      cfg_write(ps, en, typ);
      if (legal(ps)) begin expv = {ps, en, typ}; any = 1'b1; end
      else nbad++;
    end
    idle(); idle(); #2;
    check("cfg_busy_while_frame", 32'(bus.cfg_busy), 32'(any));
    check("cfg_err_pulses", 32'(err_seen - e0), 32'(nbad));
    expect_live(expv);
    idle(); bus.rx_busy = 1'b0;
    wait_cfg_idle("cfg_round_settled");
    check("cfg_round_live", 32'({bus.Prescale, bus.PAR_EN, bus.PAR_TYP}), 32'(expv));
  endtask

  always begin
    @(negedge clk); #2;
    if (mon_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(occ_now > 0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(bus.out_valid), 32'd0);
        else begin
          mon_exp = exp_q.pop_front();
          check("fifo_data", 32'(bus.out_data), 32'(mon_exp));
        end
      end
      mon_cur = {bus.Prescale, bus.PAR_EN, bus.PAR_TYP};
      if (mon_cur !== prev_live) begin
        if (cfg_q.size() == 0) check("live_unexpected", 32'(mon_cur), 32'(prev_live));
        else begin
          mon_exp = cfg_q.pop_front();
          check("live_change", 32'(mon_cur), 32'(mon_exp));
        end
        prev_live = mon_cur;
      end
      if (bus.cfg_err === 1'b1) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g, n;
    logic [7:0] d;
    bus.RX_IN = 1'b1; bus.cfg_wr = 1'b0; bus.cfg_prescale = 6'd0;
    bus.cfg_par_en = 1'b0; bus.cfg_par_typ = 1'b0; bus.rx_busy = 1'b0;
    bus.rx_data = 8'h00; bus.rx_data_valid = 1'b0; bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0; bus.out_ready = 1'b0; bus.clr_stat = 1'b0;
    repeat (3) idle();
    rst = 1'b0;
    mon_en = 1'b1;
    #2;
    check("rst_prescale", 32'(bus.Prescale), 32'd16);
    check("rst_par_en", 32'(bus.PAR_EN), 32'd1);
    check("rst_par_typ", 32'(bus.PAR_TYP), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_par_cnt", 32'(bus.par_err_cnt), 32'd0);
    check("rst_stp_cnt", 32'(bus.stp_err_cnt), 32'd0);
    check("rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    bus.RX_IN = 1'b0; #1;
    check("rst_gated_lo", 32'(bus.rx_in_gated), 32'd0);
    bus.RX_IN = 1'b1; #1;
    check("rst_gated_hi", 32'(bus.rx_in_gated), 32'd1);

    // Idle-line update: apply, gate for the settle window, then release.
    expect_live({6'd8, 1'b0, 1'b1});
    cfg_write(6'd8, 1'b0, 1'b1);
    #2;
    check("upd_busy", 32'(bus.cfg_busy), 32'd1);
    check("upd_not_yet", 32'(bus.Prescale), 32'd16);
    idle(); bus.RX_IN = 1'b0; #2;
    g = (bus.rx_in_gated === 1'b1) ? 1 : 0;
    idle(); #2;
    check("upd_prescale", 32'(bus.Prescale), 32'd8);
    check("upd_par_en", 32'(bus.PAR_EN), 32'd0);
    if (bus.rx_in_gated === 1'b1) g++;
    for (int k = 0; k < 20; k++) begin
      idle(); #2;
      if (bus.rx_in_gated === 1'b1) g++;
      else break;
    end
    check("gate_cycles", 32'(g), 32'(SETTLE + 1));
    check("upd_busy_clear", 32'(bus.cfg_busy), 32'd0);
    idle(); bus.RX_IN = 1'b1;

    // Update held off by a frame in progress; last legal write wins.
    do_reset();
    idle(); bus.rx_busy = 1'b1;
    cfg_write(6'd32, 1'b1, 1'b0);
    repeat (3) idle();
    #2;
    check("hold_prescale", 32'(bus.Prescale), 32'd16);
    check("hold_busy", 32'(bus.cfg_busy), 32'd1);
    cfg_write(6'd8, 1'b1, 1'b0);
    expect_live({6'd8, 1'b1, 1'b0});
    idle(); bus.rx_busy = 1'b0;
    wait_cfg_idle("hold_settled");
    check("hold_final", 32'(bus.Prescale), 32'd8);

    // Illegal prescale is rejected with a single error pulse.
    cfg_write(6'd12, 1'b0, 1'b1);
    #2;
    check("ill_err_pulse", 32'(bus.cfg_err), 32'd1);
    check("ill_busy", 32'(bus.cfg_busy), 32'd0);
    idle(); #2;
    check("ill_err_gone", 32'(bus.cfg_err), 32'd0);
    check("ill_live", 32'({bus.Prescale, bus.PAR_EN, bus.PAR_TYP}), 32'(m_live));

    // Write landing in the settle window is applied afterwards.
    expect_live({6'd32, 1'b0, 1'b0});
    cfg_write(6'd32, 1'b0, 1'b0);
    idle();
    cfg_write(6'd16, 1'b1, 1'b1);
    expect_live({6'd16, 1'b1, 1'b1});
    wait_cfg_idle("settle_wr_done");
    check("settle_wr_live", 32'({bus.Prescale, bus.PAR_EN, bus.PAR_TYP}), 32'({6'd16, 1'b1, 1'b1}));

    repeat (8) cfg_round();

    // FIFO overflow, ordered drain, and full-with-pop.
    clr_stats();
    for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 8'hA1 + 8'(i), 1'b0);
    idle(); #2;
    check("ovf_set", 32'(bus.overflow), 32'(m_ovf));
    check("ovf_head", 32'(bus.out_data), 32'hA1);
    repeat (5) fifo_cycle(1'b0, 8'h00, 1'b1);
    idle(); #2;
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    clr_stats();
    for (int i = 0; i < 4; i++) fifo_cycle(1'b1, 8'hB1 + 8'(i), 1'b0);
    fifo_cycle(1'b1, 8'hB5, 1'b1);
    idle(); #2;
    check("full_pop_no_ovf", 32'(bus.overflow), 32'(m_ovf));
    repeat (5) fifo_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      fifo_cycle(1'($urandom), d, 1'($urandom));
    end
    idle(); #2;
    check("rand_ovf", 32'(bus.overflow), 32'(m_ovf));
    repeat (6) fifo_cycle(1'b0, 8'h00, 1'b1);

    // Saturating counters and clear priority.
    clr_stats();
    for (int i = 0; i < 300; i++) begin idle(); bus.rx_par_err = 1'b1; end
    idle(); bus.rx_par_err = 1'b0; #2;
    check("par_sat", 32'(bus.par_err_cnt), 32'd255);
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin idle(); bus.rx_stp_err = 1'b1; idle(); bus.rx_stp_err = 1'b0; end
    idle(); #2;
    check("stp_count", 32'(bus.stp_err_cnt), 32'(n));
    idle(); bus.clr_stat = 1'b1; bus.rx_stp_err = 1'b1;
    idle(); bus.clr_stat = 1'b0; bus.rx_stp_err = 1'b0; m_ovf = 1'b0; #2;
    check("clr_beats_stp", 32'(bus.stp_err_cnt), 32'd0);
    check("clr_par", 32'(bus.par_err_cnt), 32'd0);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    // Reset in the middle of a pending update and with bytes buffered.
    idle(); bus.rx_busy = 1'b1;
    cfg_write(6'd32, 1'b0, 1'b1);
    fifo_cycle(1'b1, 8'h5A, 1'b0);
    fifo_cycle(1'b1, 8'h5B, 1'b0);
    idle(); #2;
    check("mid_busy", 32'(bus.cfg_busy), 32'd1);
    do_reset(); #2;
    check("mid_rst_busy", 32'(bus.cfg_busy), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_live", 32'({bus.Prescale, bus.PAR_EN, bus.PAR_TYP}), 32'(DEF_LIVE));
    idle(); bus.rx_busy = 1'b0;
    repeat (10) idle();
    #2;
    check("mid_discarded", 32'({bus.Prescale, bus.PAR_EN, bus.PAR_TYP}), 32'(DEF_LIVE));

    idle(); #3;
    check("fifo_queue_drained", 32'(exp_q.size()), 32'd0);
    check("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_sched.md
Name: uart_rx_sched

Overview:
- Configuration and frame-scheduling controller in front of the UART RX core.
- Owns the live RX settings (Prescale, PAR_EN, PAR_TYP) and only applies host updates between frames, so a frame is never received with mixed settings.
- Buffers received bytes in a 4-entry FIFO with a valid/ready pop port to the host.
- Counts parity and stop errors.

Parameters:
- FIFO_DEPTH, 4, byte buffer entries (power of two, >=2).
- SETTLE_CYC, 4, cycles RX_IN is held high after a config change.
- ERR_W, 8, width of each saturating error counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line from pad.
- rx_in_gated  out  1  serial line to RX core; forced 1 while gating.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_prescale  in  6  requested oversampling (legal: 8, 16, 32).
- cfg_par_en  in  1  requested parity enable.
- cfg_par_typ  in  1  requested parity type (0 even, 1 odd).
- cfg_err  out  1  one-cycle pulse: illegal prescale, write dropped.
- cfg_busy  out  1  a config update is pending or settling.
- Prescale  out  6  live setting to RX core.
- PAR_EN  out  1  live setting to RX core.
- PAR_TYP  out  1  live setting to RX core.
- rx_busy  in  1  RX core enable (frame in progress).
- rx_data  in  8  RX core parallel byte.
- rx_data_valid  in  1  one-cycle good-frame strobe.
- rx_par_err  in  1  parity error pulse.
- rx_stp_err  in  1  stop error pulse.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  host pop; pop occurs when out_valid and out_ready are both 1.
- overflow  out  1  sticky; cleared by clr_stat.
- par_err_cnt  out  ERR_W  saturating count of rx_par_err pulses.
- stp_err_cnt  out  ERR_W  saturating count of rx_stp_err pulses.
- clr_stat  in  1  clears overflow and both counters.

Behaviour:
- Reset values: Prescale=16, PAR_EN=1, PAR_TYP=0; FIFO empty; out_valid=0, out_data=0; all counters and flags 0; cfg_busy=0, cfg_err=0; state RUN; rx_in_gated follows RX_IN.
- Config FSM states: RUN, PEND, APPLY, SETTLE.
- RUN:
  - cfg_wr with illegal prescale -> cfg_err pulses for 1 cycle the next cycle; state stays RUN.
  - cfg_wr with legal prescale -> latch request into shadow registers, go to PEND; cfg_busy=1.
- PEND:
  - A new legal cfg_wr overwrites the shadow registers (last write wins).
  - An illegal cfg_wr pulses cfg_err and keeps the old shadow values.
  - Move to APPLY on the first cycle with rx_busy=0 and RX_IN=1 (line idle, no frame started).
- APPLY (1 cycle):
  - rx_in_gated forced 1.
  - Live outputs load the shadow values at the end of the cycle.
  - Next state SETTLE; settle counter loads SETTLE_CYC-1.
- SETTLE:
  - rx_in_gated forced 1; counter decrements.
  - At 0 go to RUN with cfg_busy=0.
  - A cfg_wr received here is latched and the FSM goes to PEND after SETTLE.
- Outside APPLY and SETTLE, rx_in_gated = RX_IN (combinational, no added latency).
- FIFO:
  - Push on rx_data_valid; data is visible on out_data 1 cycle later.
  - Full with no pop in the same cycle: byte dropped, overflow set.
  - Full with a simultaneous pop: push accepted, no overflow.
  - Empty: a pop is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH; full/empty are tracked by an occupancy count.
- Counters:
  - Increment by 1 per error pulse, saturate at all-ones.
  - clr_stat has priority over an increment in the same cycle; result is 0.
- Reset mid-operation: pending config is discarded, live outputs return to defaults, FIFO is flushed.

Decomposition:
- Package uart_rx_pkg holds:
  - state encoding constants;
  - default Prescale/PAR_EN/PAR_TYP;
  - the legal prescale values 8, 16, 32;
  - ERR_W default.
- One sub-module, sync_fifo (parameterised width and depth, push/pop/full/empty/count), instantiated for the byte buffer.

Test Plan:
- Reset, then cfg_wr prescale=8, par_en=0 while idle -> cfg_busy=1; Prescale=8 and PAR_EN=0 two cycles later; rx_in_gated=1 for SETTLE_CYC+1 cycles; then cfg_busy=0.
- cfg_wr prescale=32 while rx_busy=1 -> Prescale stays 16 until rx_busy falls; a second write prescale=8 during PEND -> final Prescale=8.
- cfg_wr prescale=12 -> cfg_err is a single pulse; Prescale, PAR_EN, PAR_TYP and cfg_busy unchanged.
- Five rx_data_valid bytes 0xA1..0xA5 with out_ready=0 -> FIFO holds 0xA1..0xA4 and overflow=1; then out_ready=1 pops 0xA1..0xA4 in order and out_valid drops.
- FIFO full, rx_data_valid and pop in the same cycle -> no overflow; the new byte is the last one read out.
- 300 rx_par_err pulses -> par_err_cnt=255; clr_stat coincident with a stp_err pulse -> stp_err_cnt=0.
